// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce-hasher memory front/back end.
package bitcoin_pkg;

  typedef logic [31:0] word_t;

  localparam int NUM_MSG_WORDS = 19;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_LAST,
    HASH,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/bitcoin_mem_io.sv
// Memory-side controller: reads the 19-word header, starts the hasher, waits for it,
// then writes one result word per nonce back to memory.
module bitcoin_mem_io
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output word_t             mem_write_data,
  input  word_t             mem_read_data,
  output word_t             msg_word [0:NUM_MSG_WORDS-1],
  output logic              hash_start,
  input  logic              hash_done,
  input  word_t             answer [0:NUM_NONCES-1]
);

  localparam int CNT_MAX = (NUM_MSG_WORDS > NUM_NONCES) ? NUM_MSG_WORDS : NUM_NONCES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(NUM_NONCES);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NUM_MSG_WORDS - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(NUM_NONCES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [ADDR_W-1:0]   r_msg_base;
  logic [ADDR_W-1:0]   r_out_base;
  word_t               r_msg_word [0:NUM_MSG_WORDS-1];
  word_t               r_result   [0:NUM_NONCES-1];
  logic [NUM_MSG_WORDS-1:0] w_cap_en;
  logic                w_latch_result;

  // Read data lags the address by one cycle, so word k lands while rd_cnt == k+1;
  // the final word arrives in READ_LAST after the counter has stopped.
  for (genvar gi = 0; gi < NUM_MSG_WORDS; gi++) begin : g_cap
    if (gi == NUM_MSG_WORDS - 1) begin : g_last
      assign w_cap_en[gi] = (r_state == READ_LAST);
    end else begin : g_body
      assign w_cap_en[gi] = (r_state == READ) && (r_rd_cnt == CNT_W'(gi + 1));
    end
  end

  assign w_latch_result = (r_state == WAIT) && hash_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_msg_base <= '0;
      r_out_base <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          r_rd_cnt <= '0;
          r_wr_cnt <= '0;
          if (start) begin
            r_msg_base <= message_addr;
            r_out_base <= output_addr;
          end
        end
        READ:    r_rd_cnt <= r_rd_cnt + 1'b1;
        WAIT:    r_wr_cnt <= '0;
        WRITE:   r_wr_cnt <= r_wr_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_MSG_WORDS; k++) r_msg_word[k] <= '0;
      for (int k = 0; k < NUM_NONCES; k++)    r_result[k]   <= '0;
    end else begin
      for (int k = 0; k < NUM_MSG_WORDS; k++) begin
        if (w_cap_en[k]) r_msg_word[k] <= mem_read_data;
      end
      if (w_latch_result) begin
        for (int k = 0; k < NUM_NONCES; k++) r_result[k] <= answer[k];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (start) w_state_next = READ;
      READ:      if (r_rd_cnt == RD_LAST) w_state_next = READ_LAST;
      READ_LAST: w_state_next = HASH;
      HASH:      w_state_next = WAIT;
      WAIT:      if (hash_done) w_state_next = WRITE;
      WRITE:     if (r_wr_cnt == WR_LAST) w_state_next = DONE;
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_write_data = '0;
    hash_start     = 1'b0;
    done           = 1'b0;
    case (r_state)
      READ: mem_addr = r_msg_base + ADDR_W'(r_rd_cnt);
      HASH: hash_start = 1'b1;
      WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = r_out_base + ADDR_W'(r_wr_cnt);
        mem_write_data = r_result[r_wr_cnt[IDX_W-1:0]];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign msg_word = r_msg_word;

endmodule

// File: tb/tb_bitcoin_mem_io.sv
// Self-checking bench for bitcoin_mem_io: cycle-accurate expectations derived from the
// run timeline (reads 1..19, hash_start 21, writes W+1..W+N, done W+N+1) against a word memory.
module tb_bitcoin_mem_io;

  localparam int NN = 16;
  localparam int NW = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] msg_word [0:NW-1];
  logic        hash_start;
  logic        hash_done;
  logic [31:0] answer [0:NN-1];

  logic [31:0] mem     [0:65535];
  logic [31:0] hdr     [0:NW-1];
  logic [31:0] exp_ans [0:NN-1];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  bitcoin_mem_io #(.NUM_NONCES(NN), .ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .done           (done),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .msg_word       (msg_word),
    .hash_start     (hash_start),
    .hash_done      (hash_done),
    .answer         (answer)
  );

  // One complete (or reset-truncated) run. Cycle 0 is the IDLE cycle where start is seen.
  // hd_mode: 0 = hash_done pulse at w, 1 = level from w, 2 = tied high (w must be 22).
  task automatic run_txn(input logic [15:0] mb, input logic [15:0] ob, input int w,
                         input int hd_mode, input bit spur, input bit hold,
                         input int rst_at, input bit basic, input string tag);
    int          last;
    int          nwr;
    int          txn_fail;
    bit          exp_we;
    logic [15:0] a;
    logic [31:0] e;
    txn_fail = n_fail;
    for (int i = 0; i < NN; i++) begin
      exp_ans[i] = basic ? (32'hA000_0000 + 32'(i)) : $urandom;
      mem[ob + 16'(i)] = 32'hDEAD_0000 | 32'(i);
    end
    for (int k = 0; k < NW; k++) begin
      hdr[k] = basic ? 32'(k + 1) : $urandom;
      mem[mb + 16'(k)] = hdr[k];
    end
    message_addr = mb;
    output_addr  = ob;
    last = (rst_at >= 0) ? rst_at + 10 : w + NN + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      start     = hold || (c == 0) || (spur && (c == 5 || c == 25));
      hash_done = (hd_mode == 2) || (hd_mode == 1 ? (c >= w) : (c == w)) || (spur && c == 7);
      reset     = (c == rst_at);
      for (int i = 0; i < NN; i++)
        answer[i] = (c >= w || hd_mode == 2) ? exp_ans[i] : ~exp_ans[i];
      if (rst_at < 0 || c <= rst_at) begin
        exp_we = (c >= w + 1) && (c <= w + NN);
        n_cmp++;
        if (mem_we !== exp_we) begin
          n_fail++;
          $display("FAIL %s mem_we c=%0d: got %b expected %b", tag, c, mem_we, exp_we);
        end
        n_cmp++;
        if (hash_start !== (c == 21)) begin
          n_fail++;
          $display("FAIL %s hash_start c=%0d: got %b expected %b", tag, c, hash_start, (c == 21));
        end
        n_cmp++;
        if (done !== (c == w + NN + 1)) begin
          n_fail++;
          $display("FAIL %s done c=%0d: got %b expected %b", tag, c, done, (c == w + NN + 1));
        end
        if (c >= 1 && c <= NW) begin
          a = mb + 16'(c - 1);
          n_cmp++;
          if (mem_addr !== a) begin
            n_fail++;
            $display("FAIL %s read_addr c=%0d: got %h expected %h", tag, c, mem_addr, a);
          end
        end
        if (exp_we) begin
          a = ob + 16'(c - w - 1);
          e = exp_ans[c - w - 1];
          n_cmp++;
          if (mem_addr !== a) begin
            n_fail++;
            $display("FAIL %s write_addr c=%0d: got %h expected %h", tag, c, mem_addr, a);
          end
          n_cmp++;
          if (mem_write_data !== e) begin
            n_fail++;
            $display("FAIL %s write_data c=%0d: got %h expected %h", tag, c, mem_write_data, e);
          end
        end
        if (c == 21 || c == w + NN + 1) begin
          for (int k = 0; k < NW; k++) begin
            n_cmp++;
            if (msg_word[k] !== hdr[k]) begin
              n_fail++;
              $display("FAIL %s msg_word[%0d] c=%0d: got %h expected %h", tag, k, c, msg_word[k], hdr[k]);
            end
          end
        end
      end else begin
        n_cmp++;
        if (mem_we !== 1'b0 || done !== 1'b0 || hash_start !== 1'b0) begin
          n_fail++;
          $display("FAIL %s post_reset c=%0d: got we=%b done=%b hs=%b expected 0 0 0",
                   tag, c, mem_we, done, hash_start);
        end
        if (c == rst_at + 1) begin
          n_cmp++;
          if (mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL %s post_reset_addr: got %h expected 0000", tag, mem_addr);
          end
          for (int k = 0; k < NW; k++) begin
            n_cmp++;
            if (msg_word[k] !== 32'h0) begin
              n_fail++;
              $display("FAIL %s post_reset_msg[%0d]: got %h expected 00000000", tag, k, msg_word[k]);
            end
          end
        end
      end
    end
    nwr = (rst_at >= 0) ? rst_at - w : NN;
    for (int i = 0; i < NN; i++) begin
      a = ob + 16'(i);
      e = (i < nwr) ? exp_ans[i] : (32'hDEAD_0000 | 32'(i));
      n_cmp++;
      if (mem[a] !== e) begin
        n_fail++;
        $display("FAIL %s mem[%h]: got %h expected %h", tag, a, mem[a], e);
      end
    end
    $display("txn %-8s msg=%h out=%h W=%0d hd_mode=%0d rst_at=%0d errors=%0d",
             tag, mb, ob, w, hd_mode, rst_at, n_fail - txn_fail);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b1;
    hash_done    = 1'b0;
    message_addr = 16'h1234;
    output_addr  = 16'h5678;
    for (int i = 0; i < NN; i++) answer[i] = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || hash_start !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got done=%b hs=%b we=%b expected 0 0 0", done, hash_start, mem_we);
    end
    n_cmp++;
    if (mem_addr !== 16'h0 || mem_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h data=%h expected 0000 00000000", mem_addr, mem_write_data);
    end
    for (int k = 0; k < NW; k++) begin
      n_cmp++;
      if (msg_word[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_msg[%0d]: got %h expected 00000000", k, msg_word[k]);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_addr !== 16'h0 || mem_we !== 1'b0 || hash_start !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wins c=%0d: got addr=%h we=%b hs=%b expected 0000 0 0",
                 c, mem_addr, mem_we, hash_start);
      end
    end
    $display("txn reset    start+reset together, idle held 25 cycles");
  endtask

  task automatic test_basic();
    run_txn(16'h0000, 16'h0040, 30, 0, 1'b0, 1'b0, -1, 1'b1, "basic");
  endtask

  task automatic test_early_done();
    run_txn(16'h0100, 16'h0200, 22, 2, 1'b0, 1'b0, -1, 1'b0, "early");
  endtask

  task automatic test_wrap();
    run_txn(16'hFFF0, 16'hFFFA, 30, 1, 1'b0, 1'b0, -1, 1'b0, "wrap");
  endtask

  task automatic test_reset_mid_write();
    run_txn(16'h0300, 16'h0400, 26, 0, 1'b0, 1'b0, 26 + 5, 1'b0, "rst_wr");
    run_txn(16'h0300, 16'h0400, 28, 1, 1'b0, 1'b0, -1, 1'b0, "rerun");
  endtask

  task automatic test_spurious();
    run_txn(16'h0000, 16'h0040, 30, 0, 1'b1, 1'b0, -1, 1'b1, "spurious");
  endtask

  task automatic test_random();
    logic [15:0] mb;
    logic [15:0] ob;
    for (int t = 0; t < 4; t++) begin
      mb = 16'($urandom);
      ob = mb + 16'h0100 + 16'($urandom_range(0, 255));
      run_txn(mb, ob, int'($urandom_range(22, 40)), int'($urandom_range(0, 1)),
              1'b0, 1'b0, -1, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_txn(16'h0800, 16'h0900, 24, 0, 1'b0, 1'b1, -1, 1'b0, "b2b_1");
    run_txn(16'h0A00, 16'h0B00, 27, 1, 1'b0, 1'b1, -1, 1'b0, "b2b_2");
    @(negedge clk);
    start     = 1'b0;
    hash_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_done();
    test_wrap();
    test_reset_mid_write();
    test_spurious();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
